// File: rtl/mem_responder_pkg.sv
// Shared definitions for the KS10 backplane memory responder: flag bit
// positions in the address word, FSM states and the status register IO address.
package mem_responder_pkg;

   localparam int unsigned FLAG_READ   = 3;
   localparam int unsigned FLAG_WRTEST = 4;
   localparam int unsigned FLAG_WRITE  = 5;
   localparam int unsigned FLAG_PHYS   = 8;
   localparam int unsigned FLAG_IO     = 10;

   localparam logic [21:0] STAT_IO_ADDR = 22'o100000;

   typedef enum logic [1:0] {
      IDLE,
      ACCESS,
      WAIT,
      ACK
   } stateT;

endpackage

// File: rtl/mem_responder_ram.sv
// Single-port synchronous word RAM, 36-bit words, registered read data.
// A write cycle leaves the read register unchanged.
module mem_responder_ram
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH = 15
) (
   input  logic                  clk,
   input  logic                  en,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] addr,
   input  logic [0:35]           wdata,
   output logic [0:35]           rdata
);

   logic [0:35] mem [0:(2**ADDR_WIDTH)-1];

   always_ff @(posedge clk) begin
      if (en) begin
         if (we) mem[addr] <= wdata;
         else    rdata     <= mem[addr];
      end
   end

endmodule

// File: rtl/mem_responder.sv
// KS10 backplane memory responder: decodes bus requests, services reads/writes
// after WAIT_STATES cycles and returns a one-cycle ACK. Option: MEMRESP_STATREG_EN.
module mem_responder
   import mem_responder_pkg::*;
#(
   parameter int unsigned ADDR_WIDTH  = 15,
   parameter int unsigned WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        busREQI,
   input  logic [0:35] busADDRI,
   input  logic [0:35] busDATAI,
   output logic        busACKO,
   output logic [0:35] busDATAO
);

   stateT                 state, stateNext;
   logic [3:0]            waitCnt, waitNext;
   logic [21:0]           addrField;
   logic                  isRead, isWrite, isIo, inRange;
   logic                  memSel, statSel, sel, accept;
   logic [ADDR_WIDTH-1:0] reqIdx;
   logic [0:35]           reqData;
   logic                  reqWr, reqStat;
   logic                  ramEn;
   logic [0:35]           ramRdata, statWord, readWord;
   logic                  unusedFlags;

   assign addrField   = busADDRI[14:35];
   assign isRead      = busADDRI[FLAG_READ];
   assign isWrite     = busADDRI[FLAG_WRITE];
   assign isIo        = busADDRI[FLAG_IO];
   assign unusedFlags = ^{busADDRI[0:2], busADDRI[FLAG_WRTEST], busADDRI[6:7],
                          busADDRI[FLAG_PHYS], busADDRI[9], busADDRI[11:13]};

   // Upper address bits must be zero: no wrap into implemented memory.
   assign inRange = (addrField >> ADDR_WIDTH) == 22'd0;
   assign memSel  = busREQI & ~isIo & (isRead | isWrite) & inRange;
   assign sel     = memSel | statSel;
   assign accept  = sel & (state == IDLE);

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         waitCnt <= '0;
      end else begin
         state   <= stateNext;
         waitCnt <= waitNext;
      end
   end

   always_ff @(posedge clk) begin
      if (accept && !rst) begin
         reqIdx  <= addrField[ADDR_WIDTH-1:0];
         reqData <= busDATAI;
         reqWr   <= isWrite & ~isRead;
         reqStat <= statSel;
      end
   end

   always_comb begin
      stateNext = state;
      waitNext  = waitCnt;
      case (state)
         IDLE:   if (accept) stateNext = ACCESS;
         ACCESS: begin
            waitNext  = 4'(WAIT_STATES);
            stateNext = (WAIT_STATES > 0) ? WAIT : ACK;
         end
         WAIT: begin
            waitNext = waitCnt - 4'd1;
            if (waitCnt <= 4'd1) stateNext = ACK;
         end
         ACK:     stateNext = IDLE;
         default: stateNext = IDLE;
      endcase
   end

   // Read issued in ACCESS; write committed at the end of ACK unless reset hits.
   assign ramEn = ~reqStat & (((state == ACCESS) & ~reqWr) | ((state == ACK) & reqWr & ~rst));

   mem_responder_ram #(.ADDR_WIDTH(ADDR_WIDTH)) ram (
      .clk   (clk),
      .en    (ramEn),
      .we    (reqWr),
      .addr  (reqIdx),
      .wdata (reqData),
      .rdata (ramRdata)
   );

`ifdef MEMRESP_STATREG_EN
   logic sticky, dropped, stickyClr;

   assign statSel   = busREQI & isIo & (addrField == STAT_IO_ADDR);
   assign dropped   = sel & (state != IDLE);
   assign stickyClr = (state == ACK) & reqWr & reqStat & reqData[0];
   assign statWord  = {sticky, 31'd0, 4'(WAIT_STATES)};

   // A drop in the same cycle as a clear wins, so no drop is ever lost.
   always_ff @(posedge clk) begin
      if (rst) sticky <= 1'b0;
      else     sticky <= (sticky & ~stickyClr) | dropped;
   end
`else
   assign statSel  = 1'b0;
   assign statWord = '0;
`endif

   assign readWord = reqStat ? statWord : ramRdata;
   assign busACKO  = (state == ACK);
   assign busDATAO = (busACKO && !reqWr) ? readWord : '0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: instance 0 uses WAIT_STATES=2, instance 1 uses 0.
// A transaction-level model predicts ACK timing and data every cycle.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst;
   logic        req  [2];
   logic [0:35] addr [2];
   logic [0:35] din  [2];
   logic        ack  [2];
   logic [0:35] dout [2];

   int tests = 0;
   int fails = 0;

   mem_responder #(.ADDR_WIDTH(15), .WAIT_STATES(2)) dutA (
      .clk(clk), .rst(rst), .busREQI(req[0]), .busADDRI(addr[0]),
      .busDATAI(din[0]), .busACKO(ack[0]), .busDATAO(dout[0]));

   mem_responder #(.ADDR_WIDTH(15), .WAIT_STATES(0)) dutB (
      .clk(clk), .rst(rst), .busREQI(req[1]), .busADDRI(addr[1]),
      .busDATAI(din[1]), .busACKO(ack[1]), .busDATAO(dout[1]));

   always #5 clk = ~clk;

   function automatic int unsigned wsOf(input int i);
      return (i == 0) ? 2 : 0;
   endfunction

   function automatic logic [0:35] mkA(input bit rd, input bit wr, input bit io, input logic [21:0] a);
      logic [0:35] w;
      w = '0;
      w[3] = rd;
      w[5] = wr;
      w[10] = io;
      w[14:35] = a;
      return w;
   endfunction

   // ---------------- model ----------------
   int unsigned cyc = 0;
   bit          modelOn = 0;
   bit          pendV    [2];
   int unsigned pendAck  [2];
   bit          pendWr   [2];
   bit          pendStat [2];
   logic [0:35] pendData [2];
   int          pendKey  [2];
   logic [0:35] rdVal    [2];
   bit          stickyM  [2];
   logic [0:35] mm [int];

   always @(posedge clk) begin
      cyc = cyc + 1;
      if (rst) modelOn = 1;
      for (int i = 0; i < 2; i++) begin
         if (rst) begin
            pendV[i]   = 0;
            stickyM[i] = 0;
         end else begin
            bit          busy, rd, wr, io, mSel, sSel;
            logic [21:0] f;
            busy = pendV[i];
            if (pendV[i] && cyc == pendAck[i] + 1) begin
               if (pendWr[i]) begin
                  if (pendStat[i]) begin
                     if (pendData[i][0]) stickyM[i] = 0;
                  end else mm[pendKey[i]] = pendData[i];
               end
               pendV[i] = 0;
            end
            if (req[i]) begin
               rd = addr[i][3];
               wr = addr[i][5];
               io = addr[i][10];
               f  = addr[i][14:35];
               mSel = !io && (rd || wr) && (int'(f) < 32768);
`ifdef MEMRESP_STATREG_EN
               sSel = io && (f == 22'o100000);
`else
               sSel = 0;
`endif
               if (mSel || sSel) begin
                  if (busy) begin
                     if (sSel || mSel) stickyM[i] = sSel | mSel;
`ifndef MEMRESP_STATREG_EN
                     stickyM[i] = 0;
`endif
                  end else begin
                     pendV[i]    = 1;
                     pendAck[i]  = cyc + 1 + wsOf(i);
                     pendWr[i]   = wr && !rd;
                     pendStat[i] = sSel;
                     pendData[i] = din[i];
                     pendKey[i]  = (i << 24) | int'(f);
                     rdVal[i]    = mm.exists(pendKey[i]) ? mm[pendKey[i]] : '0;
                  end
               end
            end
         end
      end
   end

   always @(negedge clk) begin
      if (modelOn) begin
         for (int i = 0; i < 2; i++) begin
            logic        eAck;
            logic [0:35] eD;
            eAck = pendV[i] && (cyc == pendAck[i]);
            eD   = '0;
            if (eAck && !pendWr[i])
               eD = pendStat[i] ? {stickyM[i], 31'd0, 4'(wsOf(i))} : rdVal[i];
            tests++;
            if (ack[i] !== eAck || dout[i] !== eD) begin
               fails++;
               $display("FAIL cycleCheck inst%0d cyc%0d: ack=%b data=%o, required ack=%b data=%o",
                        i, cyc, ack[i], dout[i], eAck, eD);
            end
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic doReq(input int i, input logic [0:35] a, input logic [0:35] d);
      @(posedge clk); #1;
      req[i] = 1'b1; addr[i] = a; din[i] = d;
      @(posedge clk); #1;
      req[i] = 1'b0; addr[i] = '0; din[i] = '0;
   endtask

   task automatic expectAck(input int i, input int expCyc, input logic [0:35] expD, input string nm);
      int          lat = -1;
      logic [0:35] got = '0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (ack[i]) begin
            lat = k + 1;
            got = dout[i];
            break;
         end
      end
      tests++;
      if (lat != expCyc || got !== expD) begin
         fails++;
         $display("FAIL %s: ackCycle=N+%0d data=%o, required ackCycle=N+%0d data=%o",
                  nm, lat, got, expCyc, expD);
      end
   endtask

   task automatic countAcks(input int i, input string nm, input int expN);
      int n = 0;
      int badData = 0;
      for (int k = 0; k < 32; k++) begin
         @(negedge clk);
         if (ack[i]) n++;
         else if (dout[i] !== '0) badData++;
      end
      tests++;
      if (n != expN || badData != 0) begin
         fails++;
         $display("FAIL %s: acks=%0d idleNonzeroData=%0d, required acks=%0d idleNonzeroData=0",
                  nm, n, badData, expN);
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation did not finish, required completion");
      $fatal(1, "timeout");
   end

   initial begin
      rst = 1'b1;
      for (int i = 0; i < 2; i++) begin
         req[i] = 1'b0; addr[i] = '0; din[i] = '0;
      end
      repeat (3) @(posedge clk);
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
         tests++;
         if (ack[i] !== 1'b0 || dout[i] !== '0) begin
            fails++;
            $display("FAIL resetState inst%0d: ack=%b data=%o, required ack=0 data=0", i, ack[i], dout[i]);
         end
      end
      @(posedge clk); #1 rst = 1'b0;

      // Write then read, WAIT_STATES=2
      doReq(0, mkA(0, 1, 0, 22'o100), 36'o123456701234);
      expectAck(0, 4, '0, "writeAck");
      doReq(0, mkA(1, 0, 0, 22'o100), '0);
      expectAck(0, 4, 36'o123456701234, "readBack");

      // Read-modify-write
      doReq(0, mkA(1, 1, 0, 22'o100), 36'o555);
      expectAck(0, 4, 36'o123456701234, "rmwRead");
      doReq(0, mkA(0, 1, 0, 22'o100), 36'o777777777777);
      expectAck(0, 4, '0, "rmwWrite");
      doReq(0, mkA(1, 0, 0, 22'o100), '0);
      expectAck(0, 4, 36'o777777777777, "rmwReadBack");

      // Unowned addresses
      doReq(0, mkA(1, 0, 0, 22'o100000), '0);
      countAcks(0, "outOfRange", 0);
      doReq(0, mkA(1, 0, 1, 22'o100), '0);
      countAcks(0, "ioRead", 0);
      doReq(0, mkA(0, 0, 0, 22'o100), '0);
      countAcks(0, "noOpFlag", 0);

      // Second request while busy is dropped
      @(posedge clk); #1;
      req[0] = 1'b1; addr[0] = mkA(1, 0, 0, 22'o100);
      @(posedge clk); #1;
      @(posedge clk); #1;
      req[0] = 1'b0; addr[0] = '0;
      countAcks(0, "busyDrop", 1);

`ifdef MEMRESP_STATREG_EN
      doReq(0, mkA(1, 0, 1, 22'o100000), '0);
      expectAck(0, 4, 36'o400000000002, "statRead");
      doReq(0, mkA(0, 1, 1, 22'o100000), 36'o400000000000);
      expectAck(0, 4, '0, "statClear");
      doReq(0, mkA(1, 0, 1, 22'o100000), '0);
      expectAck(0, 4, 36'o000000000002, "statReread");
`endif

      // Reset during WAIT of a write: RAM keeps the old word
      doReq(0, mkA(0, 1, 0, 22'o200), 36'o111);
      expectAck(0, 4, '0, "preWrite");
      doReq(0, mkA(0, 1, 0, 22'o200), 36'o222);
      @(posedge clk); #1 rst = 1'b1;
      @(posedge clk); #1 rst = 1'b0;
      countAcks(0, "resetAbort", 0);
      doReq(0, mkA(1, 0, 0, 22'o200), '0);
      expectAck(0, 4, 36'o111, "resetPreserve");

      // WAIT_STATES=0 sweep
      for (int k = 0; k < 64; k++) begin
         logic [21:0] a;
         logic [0:35] d;
         a = 22'(k * 37 + 5);
         d = 36'(k) * 36'o1010101 ^ 36'o707070707070;
         doReq(1, mkA(0, 1, 0, a), d);
         expectAck(1, 2, '0, "sweepWrite");
         doReq(1, mkA(1, 0, 0, a), '0);
         expectAck(1, 2, d, "sweepRead");
      end

      repeat (4) @(posedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
